// File: rtl/ap_cam_seq.sv
// Sequenced associative-processor CAM: addressed and tagged masked writes,
// masked parallel compare with tag combine, and match count/first/any summary.
module ap_cam_seq #(
    parameter  int WORD_SIZE  = 8,
    parameter  int CELL_QUANT = 128,
    localparam int AW         = $clog2(CELL_QUANT),
    localparam int CW         = AW + 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [1:0]            cmd_tag_mode,
    input  logic [AW-1:0]         addr_in,
    input  logic [WORD_SIZE-1:0]  dina,
    input  logic [WORD_SIZE-1:0]  key,
    input  logic [WORD_SIZE-1:0]  mask,
    output logic                  rsp_valid,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic [CELL_QUANT-1:0] tags,
    output logic                  match_any,
    output logic [AW-1:0]         match_first,
    output logic [CW-1:0]         match_count
);

    typedef enum logic [1:0] {IDLE, EXEC, COUNT} state_t;

    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_COMPARE = 3'd3;
    localparam logic [2:0] OP_TWRITE  = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;

    localparam logic [CW-1:0] ROW_LIMIT = CW'(CELL_QUANT);

    state_t state, state_next;

    logic [WORD_SIZE-1:0]  rows [CELL_QUANT];
    logic [2:0]            op;
    logic [1:0]            mode;
    logic [AW-1:0]         addr;
    logic [WORD_SIZE-1:0]  wdata;
    logic [WORD_SIZE-1:0]  key_q;
    logic [WORD_SIZE-1:0]  mask_q;

    logic                  accept;
    logic                  addr_ok;
    logic [WORD_SIZE-1:0]  rd_word;
    logic [CELL_QUANT-1:0] match;
    logic [CELL_QUANT-1:0] tags_next;
    logic [CW-1:0]         count_next;
    logic [AW-1:0]         first_next;

    assign accept  = cmd_valid & cmd_ready;
    assign addr_ok = CW'(addr) < ROW_LIMIT;
    assign rd_word = addr_ok ? rows[addr] : '0;

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = EXEC;
            end
            EXEC:    state_next = (op == OP_COMPARE) ? COUNT : IDLE;
            COUNT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < CELL_QUANT; i++)
            match[i] = ((rows[i] ^ key_q) & mask_q) == '0;
    end

    always_comb begin
        tags_next = match;
        unique case (mode)
            2'd0: tags_next = match;
            2'd1: tags_next = tags & match;
            2'd2: tags_next = tags | match;
            2'd3: tags_next = ~match;
            default: tags_next = match;
        endcase
    end

    // Scan downward so the lowest set tag wins.
    always_comb begin
        count_next = '0;
        first_next = '0;
        for (int i = CELL_QUANT - 1; i >= 0; i--) begin
            count_next = count_next + CW'(tags[i]);
            if (tags[i]) first_next = AW'(i);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELL_QUANT; i++) rows[i] <= '0;
            op          <= '0;
            mode        <= '0;
            addr        <= '0;
            wdata       <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            tags        <= '0;
            match_any   <= 1'b0;
            match_first <= '0;
            match_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                op     <= cmd_op;
                mode   <= cmd_tag_mode;
                addr   <= addr_in;
                wdata  <= dina;
                key_q  <= key;
                mask_q <= mask;
            end
            if (state == EXEC) begin
                rsp_valid <= (op != OP_COMPARE);
                rsp_data  <= '0;
                case (op)
                    OP_WRITE: begin
                        if (addr_ok)
                            rows[addr] <= (rows[addr] & ~mask_q) | (wdata & mask_q);
                    end
                    OP_READ:    rsp_data <= rd_word;
                    OP_COMPARE: tags <= tags_next;
                    OP_TWRITE: begin
                        for (int i = 0; i < CELL_QUANT; i++)
                            if (tags[i])
                                rows[i] <= (rows[i] & ~mask_q) | (wdata & mask_q);
                    end
                    OP_CLEAR:   tags <= '0;
                    default: ;
                endcase
            end
            if (state == COUNT) begin
                rsp_valid   <= 1'b1;
                match_any   <= |tags;
                match_first <= first_next;
                match_count <= count_next;
            end
        end
    end

endmodule
